fft_tw_gen: RTL and testbench

//  Parametrised radix-4 twiddle generator replacing fixed per-size twiddle ROMs. On start, streams
//  the twiddles of one radix-4 DIF stage of an N-point FFT or IFFT to the butterfly datapath over a

---
 rtl/fft_pkg.sv | 41 ++++
 rtl/fft_tw_gen_if.sv | 23 ++
 rtl/fft_tw_qrom.sv | 53 +++++
 rtl/fft_tw_gen.sv | 183 ++++++++++++++++++
 tb/tb_fft_tw_gen.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Package : fft_pkg
// Purpose : Shared definitions for the radix-4 twiddle generator: controller
//           state encoding, quadrant encoding, Q-format helpers and the
//           stage-select width function.
// Revision: 1.0  initial release
// ============================================================================
package fft_pkg;

  localparam real c_PI = 3.14159265358979323846;

  // Stage controller states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } fsm_e;

  // Quadrant of the exponent m, taken from its two MSBs.
  typedef enum logic [1:0] {
    QUAD_0 = 2'd0,
    QUAD_1 = 2'd1,
    QUAD_2 = 2'd2,
    QUAD_3 = 2'd3
  } quad_e;

  // Integer value of 1.0 in Q1.(dw-2).
  function automatic int q_one(input int dw);
    return 1 << (dw - 2);
  endfunction

  // Width of the stage select: clog2(log2n/2), never below one bit.
  function automatic int stage_w(input int log2n);
    int h;
    h = log2n / 2;
    return ($clog2(h) < 1) ? 1 : $clog2(h);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fft_tw_gen_if.sv
`default_nettype none
// ============================================================================
// Interface : fft_tw_gen_if
// Purpose   : Valid/ready twiddle stream from the generator to the butterfly.
// Signals   : out_valid  word valid
//             out_ready  consumer accepts when valid & ready
//             out_data   {imag, real}, each DW bits, two's complement
//             out_last   final word of the stage
// Modports  : master (generator), slave (butterfly)
// Revision  : 1.0  initial release
// ============================================================================
interface fft_tw_gen_if #(
  parameter int DW = 16
);
  logic            out_valid;
  logic            out_ready;
  logic [2*DW-1:0] out_data;
  logic            out_last;

  modport master (output out_valid, output out_data, output out_last, input out_ready);
  modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface
`default_nettype wire

// File: rtl/fft_tw_qrom.sv
`default_nettype none
// ============================================================================
// Module  : fft_tw_qrom
// Purpose : Quarter-wave cosine ROM, N/4+1 entries of round(cos(2*pi*i/N)
//           * 2^(DW-2)), with two synchronous read ports sharing one enable.
//           Contents are generated at elaboration from LOG2N and DW.
// Ports   : clk       clock
//           en_i      read enable (pipeline advance)
//           addr_a_i  read address A      data_a_o  C[addr_a_i], registered
//           addr_b_i  read address B      data_b_o  C[addr_b_i], registered
// Revision: 1.0  initial release
// ============================================================================
module fft_tw_qrom
  import fft_pkg::*;
#(
  parameter  int LOG2N = 6,
  parameter  int DW    = 16,
  localparam int AW    = LOG2N - 1
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic [AW-1:0] addr_a_i,
  input  logic [AW-1:0] addr_b_i,
  output logic [DW-1:0] data_a_o,
  output logic [DW-1:0] data_b_o
);

  localparam int c_DEPTH = (1 << LOG2N) / 4 + 1;

  // All entries lie in the first quadrant, so cos >= 0 and rounding is +0.5.
  function automatic logic [DW-1:0] cos_entry(input int idx);
    real ang;
    real val;
    ang = 2.0 * c_PI * real'(idx) / real'(1 << LOG2N);
    val = $cos(ang) * real'(q_one(DW));
    return DW'($rtoi(val + 0.5));
  endfunction

  logic [DW-1:0] rom_w [c_DEPTH];

  for (genvar gi = 0; gi < c_DEPTH; gi++) begin : g_rom
    assign rom_w[gi] = cos_entry(gi);
  end

  always_ff @(posedge clk) begin
    if (en_i) begin
      data_a_o <= rom_w[addr_a_i];
      data_b_o <= rom_w[addr_b_i];
    end
  end

endmodule
`default_nettype wire

// File: rtl/fft_tw_gen.sv
`default_nettype none
// ============================================================================
// Module  : fft_tw_gen
// Purpose : Streams the twiddles of one radix-4 DIF stage of an N-point
//           FFT/IFFT. For k = 0..L-1, p = 1..3 (p inner), m = p*k*4^s mod N,
//           word = {+/-sin(2*pi*m/N), cos(2*pi*m/N)} built from a quarter-
//           wave cosine table via quadrant symmetry.
// Ports   : clk, rst   clock, asynchronous active-high reset
//           start_i    start request, sampled in IDLE only
//           stage_i    radix-4 stage s
//           inv_i      1 = IFFT (+sin), 0 = FFT (-sin)
//           busy_o     accepted start until the last word handshakes
//           tw_o       twiddle stream (master side)
// Revision: 1.0  initial release
// ============================================================================
module fft_tw_gen
  import fft_pkg::*;
#(
  parameter  int LOG2N = 6,
  parameter  int DW    = 16,
  localparam int STW   = stage_w(LOG2N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  input  logic [STW-1:0] stage_i,
  input  logic           inv_i,
  output logic           busy_o,
  fft_tw_gen_if.master   tw_o
);

  localparam int c_QUARTER = (1 << LOG2N) / 4;
  localparam int KW        = LOG2N - 2;
  localparam int AW        = LOG2N - 1;

  typedef struct packed {
    logic [DW-1:0] imag;
    logic [DW-1:0] re;
  } tw_t;

  fsm_e           state_q, state_d;
  logic [STW-1:0] stage_q;
  logic           inv_q;
  logic [KW-1:0]  k_q;
  logic [1:0]     p_q;

  // P0: exponent register
  logic [LOG2N-1:0] m_q;
  logic             v0_q, last0_q;
  // P1: ROM output stage
  logic             v1_q, last1_q;
  quad_e            q1_q;
  logic [DW-1:0]    rd_r, rd_rp;
  // Output register
  logic             out_valid_q, out_last_q;
  tw_t              out_data_q;

  logic             w_en, w_issue, w_final, w_done;
  logic [STW:0]     w_shamt;
  logic [KW-1:0]    w_kmax;
  logic [LOG2N-1:0] w_pk, w_m;
  logic [AW-1:0]    w_r, w_rp;
  logic [DW-1:0]    w_cos, w_sin;
  tw_t              w_tw;

  // Every stage advances together; a stalled output freezes the whole pipe.
  assign w_en    = !out_valid_q || tw_o.out_ready;
  assign w_issue = (state_q == S_RUN) && w_en;
  assign w_shamt = {stage_q, 1'b0};
  assign w_kmax  = KW'((c_QUARTER >> w_shamt) - 1);
  assign w_final = (k_q == w_kmax) && (p_q == 2'd3);
  assign w_done  = out_valid_q && tw_o.out_ready && out_last_q;

  // p*k by shift/add, then *4^s; truncation to LOG2N bits is the mod N.
  always_comb begin
    w_pk = LOG2N'(k_q);
    case (p_q)
      2'd2:    w_pk = LOG2N'({k_q, 1'b0});
      2'd3:    w_pk = LOG2N'(k_q) + LOG2N'({k_q, 1'b0});
      default: w_pk = LOG2N'(k_q);
    endcase
    w_m = w_pk << w_shamt;
  end

  // r = m mod N/4 and its complement N/4 - r (which reaches N/4 when r = 0).
  assign w_r  = AW'(m_q[LOG2N-3:0]);
  assign w_rp = AW'(c_QUARTER) - w_r;

  fft_tw_qrom #(
    .LOG2N (LOG2N),
    .DW    (DW)
  ) u_qrom (
    .clk      (clk),
    .en_i     (w_en),
    .addr_a_i (w_r),
    .addr_b_i (w_rp),
    .data_a_o (rd_r),
    .data_b_o (rd_rp)
  );

  // Quadrant folding, then conjugation for the forward transform.
  always_comb begin
    w_cos = rd_r;
    w_sin = rd_rp;
    case (q1_q)
      QUAD_0: begin w_cos = rd_r;   w_sin = rd_rp;  end
      QUAD_1: begin w_cos = -rd_rp; w_sin = rd_r;   end
      QUAD_2: begin w_cos = -rd_r;  w_sin = -rd_rp; end
      QUAD_3: begin w_cos = rd_rp;  w_sin = -rd_r;  end
      default: ;
    endcase
    w_tw.re   = w_cos;
    w_tw.imag = inv_q ? w_sin : -w_sin;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i)            state_d = S_RUN;
      S_RUN:   if (w_issue && w_final) state_d = S_DRAIN;
      S_DRAIN: if (w_done)             state_d = S_IDLE;
      default:                         state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q     <= '0;
      inv_q       <= 1'b0;
      k_q         <= '0;
      p_q         <= 2'd1;
      m_q         <= '0;
      v0_q        <= 1'b0;
      last0_q     <= 1'b0;
      v1_q        <= 1'b0;
      last1_q     <= 1'b0;
      q1_q        <= QUAD_0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      if ((state_q == S_IDLE) && start_i) begin
        stage_q <= stage_i;
        inv_q   <= inv_i;
        k_q     <= '0;
        p_q     <= 2'd1;
      end else if (w_issue) begin
        if (p_q == 2'd3) begin
          p_q <= 2'd1;
          k_q <= k_q + 1'b1;
        end else begin
          p_q <= p_q + 2'd1;
        end
      end

      if (w_en) begin
        v0_q    <= w_issue;
        last0_q <= w_issue && w_final;
        if (w_issue) m_q <= w_m;

        v1_q    <= v0_q;
        last1_q <= last0_q;
        q1_q    <= quad_e'(m_q[LOG2N-1 -: 2]);

        out_valid_q <= v1_q;
        out_last_q  <= last1_q;
        if (v1_q) out_data_q <= w_tw;
      end
    end
  end

  assign busy_o         = (state_q != S_IDLE);
  assign tw_o.out_valid = out_valid_q;
  assign tw_o.out_last  = out_last_q;
  assign tw_o.out_data  = out_data_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_tw_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_fft_tw_gen
// Purpose : Self-checking bench for fft_tw_gen. A real-math model produces
//           the expected twiddle stream; one compare process checks every
//           handshaken word and stall stability. Extra instances sweep
//           LOG2N = 4..12 over all stages and both directions.
// Revision: 1.0  initial release
// ============================================================================
module tb_fft_tw_gen;

  localparam real c_PI = 3.14159265358979323846;

  logic       clk;
  logic       rst;
  logic       sw_rst;
  logic       start;
  logic [1:0] stage;
  logic       inv;
  logic       busy;
  logic       rnd_ready;

  int errors;
  int checks;
  int cap_n;
  int sw_done;
  time last_hs_t;

  logic [31:0] exp_d[$];
  logic        exp_l[$];
  logic [31:0] cap [128];
  logic [15:0] re1 [48];

  fft_tw_gen_if #(.DW(16)) tw ();

  fft_tw_gen #(.LOG2N(6), .DW(16)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start),
    .stage_i (stage),
    .inv_i   (inv),
    .busy_o  (busy),
    .tw_o    (tw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] expv);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
    end
  endtask

  function automatic int rnd(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    else          return -$rtoi(0.5 - x);
  endfunction

  // Word j of stage s: k = j/3, p = j%3+1, m = p*k*4^s mod N.
  function automatic logic [31:0] model_word(input int lg, input int s, input bit iv, input int j);
    int  n, k, p, m;
    real a, c, sn;
    n  = 1 << lg;
    k  = j / 3;
    p  = j % 3 + 1;
    m  = (p * k * (1 << (2 * s))) % n;
    a  = 2.0 * c_PI * real'(m) / real'(n);
    c  = $cos(a) * 16384.0;
    sn = $sin(a) * 16384.0 * (iv ? 1.0 : -1.0);
    return {16'(rnd(sn)), 16'(rnd(c))};
  endfunction

  // Output-ready driver: always ready, or ~30% low when randomised.
  initial begin
    tw.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tw.out_ready = rnd_ready ? ($urandom_range(0, 99) >= 30) : 1'b1;
    end
  end

  // Compare process: every handshake against the model queue, plus data
  // stability across stalled cycles.
  logic        hold_v;
  logic [31:0] hold_d;
  logic [31:0] ew;
  logic        el;
  initial hold_v = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v && tw.out_valid)
        check(tw.out_data == hold_d, "stall_stable", tw.out_data, hold_d);
      hold_v = tw.out_valid && !tw.out_ready;
      hold_d = tw.out_data;
      if (tw.out_valid && tw.out_ready) begin
        if (exp_d.size() == 0) begin
          check(1'b0, "extra_word", tw.out_data, 32'h0);
        end else begin
          ew = exp_d.pop_front();
          el = exp_l.pop_front();
          check(tw.out_data == ew, $sformatf("word_data_%0d", cap_n), tw.out_data, ew);
          check(tw.out_last == el, $sformatf("word_last_%0d", cap_n),
                {31'b0, tw.out_last}, {31'b0, el});
        end
        if (cap_n < 128) cap[cap_n] = tw.out_data;
        cap_n++;
        if (tw.out_last) last_hs_t = $time;
      end
    end
  end

  task automatic run_stage(input int s, input bit iv, input bit rr, input bit lat, input int poke);
    int nl;
    int cyc;
    nl = 16 >> (2 * s);
    for (int j = 0; j < 3 * nl; j++) begin
      exp_d.push_back(model_word(6, s, iv, j));
      exp_l.push_back(j == 3 * nl - 1);
    end
    cap_n     = 0;
    rnd_ready = rr;
    @(posedge clk); #1;
    stage = 2'(s);
    inv   = iv;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check(busy == 1'b1, "busy_after_start", {31'b0, busy}, 32'h1);
    if (lat) begin
      @(posedge clk);
      @(posedge clk); #1;
      check(tw.out_valid == 1'b0, "latency_early", {31'b0, tw.out_valid}, 32'h0);
      @(posedge clk); #1;
      check(tw.out_valid == 1'b1, "latency_first", {31'b0, tw.out_valid}, 32'h1);
    end
    cyc = 0;
    while (busy && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == poke) begin
        start = 1'b1;
        stage = 2'd2;
        inv   = ~iv;
      end else begin
        start = 1'b0;
      end
    end
    start     = 1'b0;
    rnd_ready = 1'b0;
    check(!busy, "done_timeout", {31'b0, busy}, 32'h0);
    check(exp_d.size() == 0, "words_missing", exp_d.size(), 32'h0);
    check(($time - last_hs_t) == 6, "busy_fall", 32'($time - last_hs_t), 32'd6);
  endtask

  initial begin
    int cyc;
    int same;
    errors    = 0;
    checks    = 0;
    cap_n     = 0;
    sw_done   = 0;
    last_hs_t = 0;
    rst       = 1'b1;
    sw_rst    = 1'b1;
    start     = 1'b0;
    stage     = 2'd0;
    inv       = 1'b0;
    rnd_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check(busy == 1'b0, "rst_busy", {31'b0, busy}, 32'h0);
    check(tw.out_valid == 1'b0, "rst_valid", {31'b0, tw.out_valid}, 32'h0);
    check(tw.out_last == 1'b0, "rst_last", {31'b0, tw.out_last}, 32'h0);
    check(tw.out_data == 32'h0, "rst_data", tw.out_data, 32'h0);
    rst    = 1'b0;
    sw_rst = 1'b0;

    // Stage 0, IFFT, ready held high
    run_stage(0, 1'b1, 1'b0, 1'b1, 0);
    check(cap_n == 48, "s0_count", cap_n, 32'd48);
    check(cap[0] == 32'h00004000, "s0_w0", cap[0], 32'h00004000);
    check(cap[1] == 32'h00004000, "s0_w1", cap[1], 32'h00004000);
    check(cap[2] == 32'h00004000, "s0_w2", cap[2], 32'h00004000);
    check(cap[3] == 32'h06463fb1, "s0_w3", cap[3], 32'h06463fb1);
    check(cap[4] == 32'h0c7c3ec5, "s0_w4", cap[4], 32'h0c7c3ec5);
    check(cap[47] == 32'hc2c1ed6c, "s0_w47", cap[47], 32'hc2c1ed6c);
    for (int i = 0; i < 48; i++) re1[i] = cap[i][15:0];

    // Stage 0, FFT: conjugated, real parts unchanged
    run_stage(0, 1'b0, 1'b0, 1'b0, 0);
    check(cap[3] == 32'hf9ba3fb1, "s0f_w3", cap[3], 32'hf9ba3fb1);
    check(cap[35] == 32'h0646c04f, "s0f_w35", cap[35], 32'h0646c04f);
    same = 0;
    for (int i = 0; i < 48; i++) if (cap[i][15:0] == re1[i]) same++;
    check(same == 48, "inv_real_match", same, 32'd48);

    // Stage 1, IFFT
    run_stage(1, 1'b1, 1'b0, 1'b0, 0);
    check(cap_n == 12, "s1_count", cap_n, 32'd12);
    check(cap[3] == 32'h187e3b21, "s1_w3_m4", cap[3], 32'h187e3b21);
    check(cap[10] == 32'h2d41d2bf, "s1_w10_m24", cap[10], 32'h2d41d2bf);

    // Stage 2: three unit twiddles
    run_stage(2, 1'b1, 1'b0, 1'b0, 0);
    check(cap_n == 3, "s2_count", cap_n, 32'd3);
    for (int i = 0; i < 3; i++)
      check(cap[i] == 32'h00004000, $sformatf("s2_w%0d", i), cap[i], 32'h00004000);

    // Random back-pressure with a stray start while busy
    run_stage(0, 1'b1, 1'b1, 1'b0, 5);
    check(cap_n == 48, "rnd_s0_count", cap_n, 32'd48);
    run_stage(1, 1'b0, 1'b1, 1'b0, 3);
    check(cap_n == 12, "rnd_s1_count", cap_n, 32'd12);

    // Reset in the middle of a stage, then a clean full stage
    for (int j = 0; j < 48; j++) begin
      exp_d.push_back(model_word(6, 0, 1'b1, j));
      exp_l.push_back(j == 47);
    end
    cap_n = 0;
    @(posedge clk); #1;
    stage = 2'd0;
    inv   = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (cap_n < 20 && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
    end
    check(cap_n >= 20, "mid_rst_reach", cap_n, 32'd20);
    #2;
    rst = 1'b1;
    #1;
    check(busy == 1'b0, "mid_rst_busy", {31'b0, busy}, 32'h0);
    check(tw.out_valid == 1'b0, "mid_rst_valid", {31'b0, tw.out_valid}, 32'h0);
    check(tw.out_last == 1'b0, "mid_rst_last", {31'b0, tw.out_last}, 32'h0);
    check(tw.out_data == 32'h0, "mid_rst_data", tw.out_data, 32'h0);
    exp_d.delete();
    exp_l.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    run_stage(0, 1'b1, 1'b0, 1'b0, 0);
    check(cap_n == 48, "post_rst_count", cap_n, 32'd48);

    cyc = 0;
    while (sw_done < 5 && cyc < 40000) begin
      @(posedge clk);
      cyc++;
    end
    check(sw_done == 5, "sweep_timeout", sw_done, 32'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Size sweep: every stage, both directions, within 1 LSB of real math.
  for (genvar g = 0; g < 5; g++) begin : g_sw
    localparam int LG = 4 + 2 * g;
    localparam int SW = fft_pkg::stage_w(LG);

    logic          start_g;
    logic          inv_g;
    logic          busy_g;
    logic [SW-1:0] stage_g;

    fft_tw_gen_if #(.DW(16)) swi ();

    fft_tw_gen #(.LOG2N(LG), .DW(16)) u_sw (
      .clk     (clk),
      .rst     (sw_rst),
      .start_i (start_g),
      .stage_i (stage_g),
      .inv_i   (inv_g),
      .busy_o  (busy_g),
      .tw_o    (swi)
    );

    initial begin
      int          nw, got, cyc, dre, dim;
      logic [31:0] sw_ew;
      start_g       = 1'b0;
      stage_g       = '0;
      inv_g         = 1'b0;
      swi.out_ready = 1'b1;
      wait (sw_rst == 1'b0);
      for (int s = 0; s < LG / 2; s++) begin
        for (int iv = 0; iv < 2; iv++) begin
          nw  = 3 * (((1 << LG) / 4) >> (2 * s));
          got = 0;
          cyc = 0;
          @(posedge clk); #1;
          stage_g = SW'(s);
          inv_g   = iv[0];
          start_g = 1'b1;
          @(posedge clk); #1;
          start_g = 1'b0;
          while (busy_g && cyc < 4000) begin
            @(negedge clk);
            if (swi.out_valid) begin
              sw_ew = model_word(LG, s, iv[0], got);
              dre   = int'($signed(swi.out_data[15:0]))  - int'($signed(sw_ew[15:0]));
              dim   = int'($signed(swi.out_data[31:16])) - int'($signed(sw_ew[31:16]));
              check(dre >= -1 && dre <= 1 && dim >= -1 && dim <= 1 &&
                    swi.out_last == (got == nw - 1),
                    $sformatf("sweep_lg%0d_s%0d_inv%0d_w%0d_last%0d", LG, s, iv, got, swi.out_last),
                    swi.out_data, sw_ew);
              got++;
            end
            @(posedge clk); #1;
            cyc++;
          end
          check(!busy_g && got == nw, $sformatf("sweep_count_lg%0d_s%0d_inv%0d", LG, s, iv),
                got, nw);
        end
      end
      sw_done++;
    end
  end

endmodule
`default_nettype wire
